score_bus_master: RTL and testbench

- Hardware bus initiator that services the score MMIO registers in data memory, replacing the CPU software polling loop in CPU-less builds.
- Shares the data-memory port with the CPU through a req/gnt arbiter.
- On a timer, reads the point-event register, clears the events it read, updates the shadow scores, and writes both scores back.
- Tracks the win condition and supports a new-game restart.

---
 rtl/score_bus_master.sv | 176 +++++++++++++++++
 tb/tb_score_bus_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_bus_master.sv
// Bus initiator that polls the score event register, clears the events it read,
// keeps shadow scores with win detection, and writes both scores back to dmem.
module score_bus_master #(
  parameter int POLL_CYCLES = 1000,
  parameter int WIN_SCORE   = 7,
  parameter int EVENT_ADDR  = 2046,
  parameter int CLEAR_ADDR  = 2047,
  parameter int SCOREL_ADDR = 2048,
  parameter int SCORER_ADDR = 2049
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        bus_gnt,
  input  logic [31:0] q,
  input  logic        new_game,
  output logic        bus_req,
  output logic [11:0] address,
  output logic [31:0] data,
  output logic        wren,
  output logic [2:0]  score_l,
  output logic [2:0]  score_r,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_RD0  = 3'd2;
  localparam logic [2:0] S_RD1  = 3'd3;
  localparam logic [2:0] S_CLR  = 3'd4;
  localparam logic [2:0] S_WRL  = 3'd5;
  localparam logic [2:0] S_WRR  = 3'd6;
  localparam logic [2:0] S_REL  = 3'd7;

  localparam int            CW       = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(POLL_CYCLES - 1);
  localparam logic [2:0]    WIN      = 3'(WIN_SCORE);
  localparam logic [11:0]   A_EVT    = 12'(EVENT_ADDR);
  localparam logic [11:0]   A_CLR    = 12'(CLEAR_ADDR);
  localparam logic [11:0]   A_SCL    = 12'(SCOREL_ADDR);
  localparam logic [11:0]   A_SCR    = 12'(SCORER_ADDR);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ng_q, ng_d;
  logic [11:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [2:0]    score_l_q, score_l_d;
  logic [2:0]    score_r_q, score_r_d;
  logic          go_q, go_d;
  logic [1:0]    winner_q, winner_d;
  logic [2:0]    l_next, r_next;

  // Bus handshake: bus_req is held from REQ through REL; the bus is ours only
  // while bus_gnt is high, so every bus state stalls and writes are masked without it.
  assign bus_req   = (state_q != S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign wren      = bus_gnt && ((state_q == S_CLR) || (state_q == S_WRL) || (state_q == S_WRR));
  assign address   = addr_q;
  assign data      = data_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = go_q;
  assign winner    = winner_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ng_d      = ng_q | new_game;
    addr_d    = addr_q;
    data_d    = data_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    go_d      = go_q;
    winner_d  = winner_q;
    l_next    = (score_l_q < WIN) ? score_l_q + 3'd1 : score_l_q;
    r_next    = (score_r_q < WIN) ? score_r_q + 3'd1 : score_r_q;

    case (state_q)
      S_IDLE: begin
        if (ng_q || (cnt_q == CNT_LAST)) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REQ: begin
        if (bus_gnt) begin
          state_d = S_RD0;
          addr_d  = A_EVT;
        end
      end
      S_RD0: begin
        if (bus_gnt) state_d = S_RD1;
      end
      S_RD1: begin
        if (bus_gnt) begin
          // A pulse landing on this edge belongs to the next pass.
          ng_d = new_game;
          if (ng_q) begin
            score_l_d = 3'd0;
            score_r_d = 3'd0;
            go_d      = 1'b0;
            winner_d  = 2'b00;
          end else if (!go_q) begin
            score_l_d = q[0] ? l_next : score_l_q;
            score_r_d = q[1] ? r_next : score_r_q;
            if (score_l_d == WIN) begin
              go_d     = 1'b1;
              winner_d = 2'b01;
            end else if (score_r_d == WIN) begin
              go_d     = 1'b1;
              winner_d = 2'b10;
            end
          end
          if ((q[1:0] == 2'b00) && !ng_q) begin
            state_d = S_REL;
          end else begin
            state_d = S_CLR;
            addr_d  = A_CLR;
            data_d  = {30'b0, q[1:0]};
          end
        end
      end
      S_CLR: begin
        if (bus_gnt) begin
          state_d = S_WRL;
          addr_d  = A_SCL;
          data_d  = {29'b0, score_l_q};
        end
      end
      S_WRL: begin
        if (bus_gnt) begin
          state_d = S_WRR;
          addr_d  = A_SCR;
          data_d  = {29'b0, score_r_q};
        end
      end
      S_WRR: begin
        if (bus_gnt) state_d = S_REL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ng_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      go_q      <= 1'b0;
      winner_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ng_q      <= ng_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      go_q      <= go_d;
      winner_q  <= winner_d;
    end
  end

endmodule

// File: tb/tb_score_bus_master.sv
// Bench for score_bus_master: dmem event-register model, transaction-level score
// model and a write scoreboard compared after every poll.
module tb_score_bus_master;

  localparam int          POLL  = 8;
  localparam int          WIN   = 7;
  localparam logic [11:0] A_EVT = 12'd2046;
  localparam logic [11:0] A_CLR = 12'd2047;
  localparam logic [11:0] A_SCL = 12'd2048;
  localparam logic [11:0] A_SCR = 12'd2049;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_gnt = 1'b1;
  logic        new_game = 1'b0;
  logic [31:0] q;
  logic        bus_req, wren, game_over, busy;
  logic [11:0] address;
  logic [31:0] data;
  logic [2:0]  score_l, score_r, state_dbg;
  logic [1:0]  winner;

  logic [1:0]  evt_reg = 2'b00;
  logic [29:0] q_noise = '0;
  bit          rand_gnt = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [43:0] exp_q[$];
  logic [43:0] got_q[$];

  int         m_sl = 0;
  int         m_sr = 0;
  bit         m_go = 1'b0;
  logic [1:0] m_win = 2'b00;

  score_bus_master #(.POLL_CYCLES(POLL)) dut (
    .clock(clock), .rst_n(rst_n), .bus_gnt(bus_gnt), .q(q), .new_game(new_game),
    .bus_req(bus_req), .address(address), .data(data), .wren(wren),
    .score_l(score_l), .score_r(score_r), .game_over(game_over), .winner(winner),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Event register: upper read bits are noise the DUT must ignore.
  assign q = (address == A_EVT) ? {q_noise, evt_reg} : 32'h0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor and dmem clear side-effect, sampled mid-cycle.
  always begin
    @(negedge clock);
    if (rand_gnt) bus_gnt = ($urandom_range(0, 3) != 0);
    q_noise = 30'($urandom);
    #1;
    if (rst_n && wren) begin
      check_eq("wren_without_gnt", bus_gnt, 1);
      got_q.push_back({address, data});
      if (address == A_CLR) evt_reg = evt_reg & ~data[1:0];
    end
  end

  // ---------------- reference model ----------------
  task automatic model_poll(input logic [1:0] evt, input bit ng);
    if (ng) begin
      m_sl = 0; m_sr = 0; m_go = 1'b0; m_win = 2'b00;
    end else if (evt != 2'b00 && !m_go) begin
      if (evt[0] && m_sl < WIN) m_sl++;
      if (evt[1] && m_sr < WIN) m_sr++;
      if (m_sl == WIN) begin m_go = 1'b1; m_win = 2'b01; end
      else if (m_sr == WIN) begin m_go = 1'b1; m_win = 2'b10; end
    end
    if (ng || evt != 2'b00) begin
      exp_q.push_back({A_CLR, 30'b0, evt});
      exp_q.push_back({A_SCL, 32'(m_sl)});
      exp_q.push_back({A_SCR, 32'(m_sr)});
    end
  endtask

  task automatic compare_poll();
    check_eq("write_count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check_eq("write_addr_data", got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    check_eq("score_l", score_l, m_sl);
    check_eq("score_r", score_r, m_sr);
    check_eq("game_over", game_over, m_go);
    check_eq("winner", winner, m_win);
    check_eq("events_cleared", evt_reg, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while (busy && n < 200) begin @(negedge clock); n++; end
    check_eq("timeout_idle", busy, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_poll(input logic [1:0] evt, input bit ng, input bit timed);
    int n, d, exp_len;
    wait_idle();
    evt_reg = evt;
    model_poll(evt, ng);
    exp_len = (exp_q.size() > 0) ? 7 : 4;
    n = 0;
    if (ng) begin
      new_game = 1'b1;
      @(negedge clock);
      new_game = 1'b0;
      n = 1;
    end
    while (!bus_req && n < 4 * POLL + 50) begin @(negedge clock); n++; end
    check_eq("timeout_req", bus_req, 1);
    if (ng) check_eq("new_game_req_latency", (n <= 2), 1);
    d = 0;
    while (bus_req && d < 500) begin @(negedge clock); d++; end
    if (timed) check_eq("poll_length", d, exp_len);
    #2;
    compare_poll();
  endtask

  task automatic gnt_drop_poll();
    int n;
    wait_idle();
    evt_reg = 2'b01;
    model_poll(2'b01, 1'b0);
    n = 0;
    while (!(address == A_CLR && wren) && n < 4 * POLL + 50) begin @(negedge clock); #1; n++; end
    check_eq("timeout_clr", address, A_CLR);
    @(negedge clock);
    bus_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("gnt_loss_wren", wren, 0);
      check_eq("gnt_loss_addr", address, A_SCL);
      @(negedge clock);
    end
    bus_gnt = 1'b1;
    wait_idle();
    #2;
    compare_poll();
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_bus_req", bus_req, 0);
    check_eq("rst_address", address, 0);
    check_eq("rst_data", data, 0);
    check_eq("rst_wren", wren, 0);
    check_eq("rst_score_l", score_l, 0);
    check_eq("rst_score_r", score_r, 0);
    check_eq("rst_game_over", game_over, 0);
    check_eq("rst_winner", winner, 0);
    check_eq("rst_busy", busy, 0);
  endtask

  task automatic release_and_first_poll();
    int n, d;
    @(negedge clock);
    rst_n = 1'b1;
    n = 0;
    while (!bus_req && n < 50) begin @(negedge clock); n++; end
    check_eq("reset_to_req_cycles", n, POLL);
    d = 0;
    while (bus_req && d < 500) begin @(negedge clock); d++; end
    check_eq("empty_poll_length", d, 4);
    check_eq("event_read_addr", address, A_EVT);
    #2;
    compare_poll();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check_reset_outputs();
    release_and_first_poll();

    run_poll(2'b01, 1'b0, 1'b1);
    run_poll(2'b11, 1'b0, 1'b1);
    repeat (5) run_poll(2'b11, 1'b0, 1'b1);
    check_eq("win_left_game_over", game_over, 1);
    check_eq("win_left_winner", winner, 2'b01);
    run_poll(2'b10, 1'b0, 1'b1);
    run_poll(2'b00, 1'b1, 1'b1);
    gnt_drop_poll();

    repeat (25) run_poll(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), 1'b1);
    rand_gnt = 1'b1;
    repeat (25) run_poll(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), 1'b0);
    rand_gnt = 1'b0;
    @(negedge clock);
    bus_gnt = 1'b1;

    // Reset in the middle of the right-score write.
    wait_idle();
    evt_reg = 2'b10;
    n = 0;
    while (!(address == A_SCR && wren) && n < 4 * POLL + 50) begin @(negedge clock); #1; n++; end
    check_eq("timeout_wrr", address, A_SCR);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    got_q.delete();
    exp_q.delete();
    evt_reg = 2'b00;
    m_sl = 0; m_sr = 0; m_go = 1'b0; m_win = 2'b00;
    release_and_first_poll();
    run_poll(2'b10, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
